// File: rtl/m1rstctl.sv
// m1rstctl: reset request controller.
// Collects three reset sources (debounced pushbutton, keyed software write,
// lockable watchdog) and turns any of them into a fixed-width trigger_reset
// pulse for the clock/reset generator. A sticky cause register survives
// sys_rst so boot firmware can tell why the system restarted.
//
// CSR bus: csr_we is a one-cycle write strobe that takes effect at the edge
// where it is high; there is no read strobe, csr_do always returns the
// register addressed by csr_a in the previous cycle.
module m1rstctl #(
  parameter int unsigned debounce_cycles = 1000000,
  parameter int unsigned pulse_len       = 16,
  parameter logic [31:0] soft_key        = 32'hB007B007
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        btn_reset_pad,
  input  logic [1:0]  csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        trigger_reset
);

  localparam int DW = $clog2(debounce_cycles + 1);
  localparam int PW = (pulse_len > 1) ? $clog2(pulse_len) : 1;
  // The press event fires in the cycle the counter steps onto debounce_cycles.
  localparam logic [DW-1:0] deb_fire   = DW'(debounce_cycles - 1);
  localparam logic [DW-1:0] deb_max    = DW'(debounce_cycles);
  localparam logic [PW-1:0] pulse_last = PW'(pulse_len - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  // Button path
  logic          btn_s1;
  logic          btn_s2;
  logic [DW-1:0] deb_cnt;

  // Watchdog
  logic [31:0] wd_reload;
  logic        wd_en;
  logic [31:0] wd_cnt;

  // Cause register {soft, watchdog, button}; starts from the configuration
  // INIT value and is deliberately left out of sys_rst.
  logic [2:0] cause = 3'b000;

  // Pulse FSM
  state_t        state;
  logic [PW-1:0] pulse_cnt;

  // CSR write decode
  logic wr_soft;
  logic wr_reload;
  logic wr_ctrl;
  logic wr_cause;

  assign wr_soft   = csr_we && (csr_a == 2'd0);
  assign wr_reload = csr_we && (csr_a == 2'd1);
  assign wr_ctrl   = csr_we && (csr_a == 2'd2);
  assign wr_cause  = csr_we && (csr_a == 2'd3);

  // Event sources; all are held off while sys_rst is clearing their state.
  logic       soft_ev;
  logic       wd_ev;
  logic       btn_ev;
  logic [2:0] events;
  logic       any_ev;
  logic [2:0] cause_clr;

  assign soft_ev   = wr_soft && (csr_di == soft_key);
  assign wd_ev     = wd_en && (wd_cnt == 32'd0);
  assign btn_ev    = btn_s2 && (deb_cnt == deb_fire);
  assign events    = {soft_ev, wd_ev, btn_ev} & {3{~sys_rst}};
  assign any_ev    = |events;
  assign cause_clr = wr_cause ? csr_di[2:0] : 3'b000;

  // Synchronize the pad and count how long it has been stably high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      btn_s1  <= 1'b0;
      btn_s2  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      btn_s1 <= btn_reset_pad;
      btn_s2 <= btn_s1;
      if (!btn_s2) begin
        deb_cnt <= '0;
      end else if (deb_cnt != deb_max) begin
        // Saturating at deb_max keeps a long press from firing twice.
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  // Watchdog reload register, locked enable and down-counter.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wd_reload <= 32'hFFFFFFFF;
      wd_en     <= 1'b0;
      wd_cnt    <= 32'd0;
    end else begin
      if (wr_reload) begin
        wd_reload <= csr_di;
      end
      if (wr_ctrl && csr_di[0]) begin
        wd_en <= 1'b1;
      end
      // Enabling write or a kick while enabled reloads; otherwise count down.
      if (wr_ctrl && (csr_di[0] || (csr_di[1] && wd_en))) begin
        wd_cnt <= wd_reload;
      end else if (wd_en && (wd_cnt != 32'd0)) begin
        wd_cnt <= wd_cnt - 32'd1;
      end
    end
  end

  // Sticky cause bits: a new event beats a simultaneous write-1-to-clear.
  always_ff @(posedge sys_clk) begin
    cause <= (cause & ~cause_clr) | events;
  end

  // Fixed-length trigger pulse; events during a pulse do not extend it.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      pulse_cnt     <= '0;
      trigger_reset <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_ev) begin
            state         <= PULSE;
            pulse_cnt     <= pulse_last;
            trigger_reset <= 1'b1;
          end
        end
        PULSE: begin
          if (pulse_cnt == '0) begin
            state         <= IDLE;
            trigger_reset <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt - PW'(1);
          end
        end
        default: begin
          state         <= IDLE;
          trigger_reset <= 1'b0;
        end
      endcase
    end
  end

  // Registered read mux with one cycle of latency.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do <= 32'd0;
    end else begin
      case (csr_a)
        2'd0:    csr_do <= 32'd0;
        2'd1:    csr_do <= wd_reload;
        2'd2:    csr_do <= {30'd0, 1'b0, wd_en};
        default: csr_do <= {29'd0, cause};
      endcase
    end
  end

endmodule

// File: tb/tb_m1rstctl.sv
// Testbench for m1rstctl with debounce_cycles = 8 and pulse_len = 16.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// at that same point, away from the active edge.
module tb_m1rstctl;

  localparam logic [31:0] key = 32'hB007B007;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        btn_reset_pad = 1'b0;
  logic [1:0]  csr_a = 2'd0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = 32'd0;
  logic [31:0] csr_do;
  logic        trigger_reset;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  m1rstctl #(
    .debounce_cycles(8),
    .pulse_len(16),
    .soft_key(key)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .btn_reset_pad(btn_reset_pad),
    .csr_a(csr_a),
    .csr_we(csr_we),
    .csr_di(csr_di),
    .csr_do(csr_do),
    .trigger_reset(trigger_reset)
  );

  // Clock and global time limit
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic do_tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset;
    sys_rst = 1'b1;
    csr_we = 1'b0;
    csr_a = 2'd0;
    csr_di = 32'd0;
    btn_reset_pad = 1'b0;
    repeat (3) do_tick;
    sys_rst = 1'b0;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    csr_a = a;
    csr_di = d;
    csr_we = 1'b1;
    do_tick;
    csr_we = 1'b0;
    csr_di = 32'd0;
  endtask

  task automatic push_read(input logic [1:0] a, input logic [31:0] e);
    csr_a = a;
    exp_q.push_back(e);
  endtask

  task automatic push_trig(input logic v, input int n);
    repeat (n) exp_q.push_back({31'd0, v});
  endtask

  // Tests
  task automatic test_reset;
    logic [1:0]  ra[4];
    logic [31:0] re[4];
    logic [31:0] w;
    ra = '{2'd1, 2'd2, 2'd3, 2'd0};
    re = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'd0};
    apply_reset;
    checks++;
    if (trigger_reset !== 1'b0) begin
      failures++;
      $display("FAIL reset_trigger: got %b expected 0", trigger_reset);
    end
    checks++;
    if (csr_do !== 32'd0) begin
      failures++;
      $display("FAIL reset_csr_do: got %h expected 0", csr_do);
    end
    for (int i = 0; i < 4; i++) begin
      push_read(ra[i], re[i]);
      do_tick;
      w = exp_q.pop_front();
      checks++;
      if (csr_do !== w) begin
        failures++;
        $display("FAIL reset_read a=%0d: got %h expected %h", ra[i], csr_do, w);
      end
    end
  endtask

  task automatic test_soft_key;
    int hi;
    logic [31:0] w;
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd0, 32'hB007B006);
    hi = 0;
    repeat (20) begin
      if (trigger_reset === 1'b1) hi++;
      do_tick;
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL soft_badkey: high cycles %0d expected 0", hi);
    end
    csr_write(2'd0, key);
    push_trig(1'b1, 16);
    push_trig(1'b0, 4);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      checks++;
      if (trigger_reset !== w[0]) begin
        failures++;
        $display("FAIL soft_pulse: trigger %b expected %b (remaining %0d)", trigger_reset, w[0], exp_q.size());
      end
      do_tick;
    end
    push_read(2'd3, 32'd4);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL soft_cause: got %h expected %h", csr_do, w);
    end
    csr_write(2'd3, 32'd4);
    push_read(2'd3, 32'd0);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL soft_cause_clear: got %h expected %h", csr_do, w);
    end
  endtask

  task automatic test_watchdog;
    logic [31:0] w;
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd1, 32'd5);
    csr_write(2'd2, 32'd1);
    // Counter 5 after the enable edge, 0 five edges later, trigger one after.
    // A still-expired watchdog retriggers right after the pulse ends.
    push_trig(1'b0, 6);
    push_trig(1'b1, 16);
    push_trig(1'b0, 1);
    push_trig(1'b1, 1);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      checks++;
      if (trigger_reset !== w[0]) begin
        failures++;
        $display("FAIL wd_timeout: trigger %b expected %b (remaining %0d)", trigger_reset, w[0], exp_q.size());
      end
      do_tick;
    end
    push_read(2'd3, 32'd2);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL wd_cause: got %h expected %h", csr_do, w);
    end
  endtask

  task automatic test_kick;
    int hi;
    int waited;
    logic [31:0] w;
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd1, 32'd5);
    csr_write(2'd2, 32'd1);
    hi = 0;
    // Kick every 4 cycles with the enable bit written as 0.
    for (int k = 0; k < 10; k++) begin
      repeat (3) begin
        if (trigger_reset === 1'b1) hi++;
        do_tick;
      end
      if (trigger_reset === 1'b1) hi++;
      csr_write(2'd2, 32'd2);
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL kick_hold: high cycles %0d expected 0", hi);
    end
    push_read(2'd2, 32'd1);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL enable_locked: got %h expected %h", csr_do, w);
    end
    csr_write(2'd2, 32'd0);
    waited = 0;
    while (trigger_reset !== 1'b1 && waited < 20) begin
      do_tick;
      waited++;
    end
    checks++;
    if (trigger_reset !== 1'b1) begin
      failures++;
      $display("FAIL wd_after_kick: trigger %b expected 1 within 20 cycles", trigger_reset);
    end
    push_read(2'd3, 32'd2);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL kick_cause: got %h expected %h", csr_do, w);
    end
  endtask

  task automatic test_button;
    int hi;
    int i;
    logic [31:0] w;
    apply_reset;
    csr_write(2'd3, 32'd7);
    btn_reset_pad = 1'b1;
    repeat (6) do_tick;
    btn_reset_pad = 1'b0;
    hi = 0;
    repeat (30) begin
      if (trigger_reset === 1'b1) hi++;
      do_tick;
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL btn_glitch: high cycles %0d expected 0", hi);
    end
    // Pad high now: synchronized two edges later, event after 8 more
    // counted cycles minus one, trigger one edge after that.
    btn_reset_pad = 1'b1;
    push_trig(1'b0, 10);
    push_trig(1'b1, 16);
    push_trig(1'b0, 10);
    i = 0;
    while (exp_q.size() > 0) begin
      if (i == 20) btn_reset_pad = 1'b0;
      w = exp_q.pop_front();
      checks++;
      if (trigger_reset !== w[0]) begin
        failures++;
        $display("FAIL btn_press: trigger %b expected %b at step %0d", trigger_reset, w[0], i);
      end
      do_tick;
      i++;
    end
    push_read(2'd3, 32'd1);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL btn_cause: got %h expected %h", csr_do, w);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] w;
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd1, 32'd5);
    csr_write(2'd2, 32'd1);
    repeat (5) do_tick;
    // Watchdog counter is 0 in this cycle; the key write lands alongside it.
    csr_write(2'd0, key);
    push_trig(1'b1, 16);
    push_trig(1'b0, 1);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      checks++;
      if (trigger_reset !== w[0]) begin
        failures++;
        $display("FAIL simul_pulse: trigger %b expected %b (remaining %0d)", trigger_reset, w[0], exp_q.size());
      end
      do_tick;
    end
    push_read(2'd3, 32'd6);
    do_tick;
    w = exp_q.pop_front();
    checks++;
    if (csr_do !== w) begin
      failures++;
      $display("FAIL simul_cause: got %h expected %h", csr_do, w);
    end
  endtask

  task automatic test_reset_retention;
    logic [1:0]  ra[5];
    logic [31:0] re[5];
    logic [31:0] w;
    ra = '{2'd2, 2'd1, 2'd3, 2'd3, 2'd3};
    re = '{32'd0, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd0};
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd1, 32'd1000);
    csr_write(2'd2, 32'd1);
    csr_write(2'd0, key);
    do_tick;
    do_tick;
    checks++;
    if (trigger_reset !== 1'b1) begin
      failures++;
      $display("FAIL ret_pulse: trigger %b expected 1", trigger_reset);
    end
    sys_rst = 1'b1;
    do_tick;
    sys_rst = 1'b0;
    checks++;
    if (trigger_reset !== 1'b0) begin
      failures++;
      $display("FAIL ret_trig_off: trigger %b expected 0", trigger_reset);
    end
    for (int i = 0; i < 5; i++) begin
      push_read(ra[i], re[i]);
      // Clear the soft cause between the first and second cause reads.
      if (i == 3) csr_write(2'd3, 32'd4);
      else do_tick;
      w = exp_q.pop_front();
      if (i != 3) begin
        checks++;
        if (csr_do !== w) begin
          failures++;
          $display("FAIL ret_read step %0d a=%0d: got %h expected %h", i, ra[i], csr_do, w);
        end
      end
    end
  endtask

  task automatic test_read_latency;
    logic [31:0] r;
    logic [1:0]  ra[5];
    logic [31:0] re[5];
    logic [31:0] w;
    r = $urandom_range(32'h7FFFFFFF, 1);
    ra = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd1};
    re = '{r, 32'd0, 32'd0, 32'd0, r};
    apply_reset;
    csr_write(2'd3, 32'd7);
    csr_write(2'd1, r);
    for (int i = 0; i < 5; i++) begin
      push_read(ra[i], re[i]);
      do_tick;
      w = exp_q.pop_front();
      checks++;
      if (csr_do !== w) begin
        failures++;
        $display("FAIL read_latency a=%0d: got %h expected %h", ra[i], csr_do, w);
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset;
    test_soft_key;
    test_watchdog;
    test_kick;
    test_button;
    test_simultaneous;
    test_reset_retention;
    test_read_latency;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
